// File: rtl/vote_session_if.sv
// Ballot/result bundle between the voter front-end and the vote_session block.
interface vote_session_if #(
    parameter int unsigned N_VOTERS = 4
);
    localparam int unsigned CNT_W = $clog2(N_VOTERS + 1);

    logic                start;
    logic                close;
    logic [N_VOTERS-1:0] vote_valid;
    logic [N_VOTERS-1:0] vote_val;
    logic                busy;
    logic                done;
    logic                timed_out;
    logic [N_VOTERS-1:0] voted;
    logic [CNT_W-1:0]    yes_count;
    logic [2:0]          O;

    modport master (
        output start, close, vote_valid, vote_val,
        input  busy, done, timed_out, voted, yes_count, O
    );

    modport slave (
        input  start, close, vote_valid, vote_val,
        output busy, done, timed_out, voted, yes_count, O
    );
endinterface

// File: rtl/vote_session.sv
// Timed N-voter ballot session producing a registered one-hot reject/tie/pass result.
module vote_session #(
    parameter int unsigned N_VOTERS = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          rst,
    vote_session_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(N_VOTERS + 1);
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OPEN = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [CNT_W:0] N_EXT    = (CNT_W + 1)'(N_VOTERS);
    localparam logic [TMR_W-1:0] T_LAST = TMR_W'(TIMEOUT - 1);

    logic [1:0]          state_q, state_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic                timed_q, timed_n;
    logic [N_VOTERS-1:0] voted_q, voted_n;
    logic [CNT_W-1:0]    yes_q, yes_n;
    logic [2:0]          o_q, o_n;
    logic [TMR_W-1:0]    timer_q, timer_n;

    logic [N_VOTERS-1:0] accept;
    logic [CNT_W-1:0]    yes_add;
    logic [CNT_W-1:0]    yes_sum;
    logic [CNT_W:0]      twice_y;
    logic                all_voted;
    logic                tmo_hit;
    logic [2:0]          result;

    // Next-state and next-output logic for the session FSM.
    always_comb begin
        state_n   = state_q;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        timed_n   = timed_q;
        voted_n   = voted_q;
        yes_n     = yes_q;
        o_n       = o_q;
        timer_n   = timer_q;

        accept    = bus.vote_valid & ~voted_q;
        yes_add   = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            yes_add = yes_add + CNT_W'(accept[i] & bus.vote_val[i]);
        end
        yes_sum   = yes_q + yes_add;
        twice_y   = {yes_sum, 1'b0};
        all_voted = &(voted_q | accept);
        tmo_hit   = (timer_q == T_LAST);

        if (twice_y < N_EXT) begin
            result = 3'b100;
        end else if (twice_y == N_EXT) begin
            result = 3'b010;
        end else begin
            result = 3'b001;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_n = ST_OPEN;
                    busy_n  = 1'b1;
                    timed_n = 1'b0;
                    voted_n = '0;
                    yes_n   = '0;
                    o_n     = 3'b000;
                    timer_n = '0;
                end
            end
            ST_OPEN: begin
                busy_n  = 1'b1;
                voted_n = voted_q | accept;
                yes_n   = yes_sum;
                timer_n = timer_q + TMR_W'(1);
                if (all_voted || bus.close || tmo_hit) begin
                    state_n = ST_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    o_n     = result;
                    timed_n = tmo_hit && !all_voted && !bus.close;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            timed_q <= 1'b0;
            voted_q <= '0;
            yes_q   <= '0;
            o_q     <= 3'b000;
            timer_q <= '0;
        end else begin
            state_q <= state_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            timed_q <= timed_n;
            voted_q <= voted_n;
            yes_q   <= yes_n;
            o_q     <= o_n;
            timer_q <= timer_n;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.timed_out = timed_q;
    assign bus.voted     = voted_q;
    assign bus.yes_count = yes_q;
    assign bus.O         = o_q;
endmodule

// File: doc/vote_session.md
# vote_session

Sequential, parametrised successor to the team's 4-input combinational majority voter. Runs timed voting sessions for N voters: each voter casts at most one yes/no ballot per session via a per-voter valid strobe. The session closes when all voters have voted, on `close`, or on timeout. The result is registered as the same one-hot reject/tie/pass code the combinational voter produces. It sits between the voter input front-end and the result display/decision logic.

## Interface
- `N_VOTERS`, default 4: number of voters, ≥2.
- `TIMEOUT`, default 255: maximum cycles a session stays open, ≥1.
- `CNT_W`, derived: `$clog2(N_VOTERS+1)`; not to be overridden.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: open a new session (acted on in IDLE or DONE only).
- `close` input 1: force-close the open session.
- `vote_valid` input N_VOTERS: per-voter ballot strobe.
- `vote_val` input N_VOTERS: per-voter ballot, 1 = yes, 0 = no; qualified by `vote_valid`.
- `busy` output 1: session open.
- `done` output 1: one-cycle pulse when the result updates.
- `timed_out` output 1: last session closed by timeout; held with the result.
- `voted` output N_VOTERS: voters who have voted in the current/last session.
- `yes_count` output CNT_W: yes ballots accepted in the current/last session.
- `O` output 3: result, bit 2 = reject, bit 1 = tie, bit 0 = pass; one-hot once valid, 3'b000 when no valid result.

## Operation
- States:
  - IDLE: after reset.
  - OPEN: accepting ballots.
  - DONE: result held.
- IDLE/DONE + `start` → OPEN on the next edge. The same edge clears `voted`, `yes_count`, `O`, `timed_out` and the timer.
- In OPEN, `start` is ignored.
- Ballot acceptance in OPEN:
  - Voter i is accepted when `vote_valid[i]` is high and `voted[i]` is 0.
  - Acceptance sets `voted[i]` and adds `vote_val[i]` to `yes_count`.
  - Repeat strobes from an already-voted voter are ignored; ballots cannot be changed.
  - Multiple voters may vote in the same cycle; all are accepted.
  - Strobes outside OPEN are ignored.
- Close conditions in an OPEN cycle, evaluated on that cycle's updated `voted`:
  - all voters voted;
  - `close` is high;
  - the timer equals TIMEOUT-1, i.e. the TIMEOUT-th OPEN cycle.
- On close, ballots in the closing cycle are counted, and the state goes to DONE on that edge.
- Result rule, with Y = final yes count and non-voters counted as no:
  - 2·Y < N_VOTERS → `O` = 3'b100 (reject)
  - 2·Y = N_VOTERS → `O` = 3'b010 (tie; only possible for even N)
  - 2·Y > N_VOTERS → `O` = 3'b001 (pass)
- For N_VOTERS=4 this matches the existing combinational table: 0–1 yes reject, 2 tie, 3–4 pass.
- `timed_out` is set only when timeout is the sole close cause. If all-voted or `close` coincides with timeout, `timed_out` = 0.
- `busy` = 1 exactly in OPEN.
- In DONE, `O`, `yes_count`, `voted` and `timed_out` hold until the next `start`, or until `rst`.
- Comparison arithmetic is done at CNT_W+1 bits, with no overflow.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `timed_out`=0, `voted`=0, `yes_count`=0, `O`=3'b000.
- `rst` overrides everything, including in OPEN and on a close edge. The session is discarded and no `done` is produced.
- `start` sampled at edge k → `busy`=1 from k.
  - A ballot presented in the same cycle as `start` is not counted.
  - The first countable ballot is sampled at edge k+1.
- Closing ballot sampled at edge m → from edge m: `O` valid, `done`=1 for exactly one cycle, `busy`=0, final `yes_count` visible.
- With no ballots and no `close`, the session ends at edge k+TIMEOUT. `busy` is high for exactly TIMEOUT cycles.
- `start` in the cycle `done` is high (DONE) opens a new session on that edge.
- `yes_count` and `voted` update at the edge following each accepted ballot.

## Test plan
- N=4: `start`; voters 0,1,2 yes at one cycle each, voter 3 no → `done` at the 4th ballot edge, `O`=001, `yes_count`=3, `timed_out`=0.
- N=4: voters 0 and 3 yes and voters 1 and 2 no, all in one cycle → closes that edge, `O`=010. Repeat with 1 yes → `O`=100.
- N=4, TIMEOUT=8: voter 1 yes only, then strobe voter 1 again with no → `yes_count` stays 1. Close at `start`+8 edges → `timed_out`=1, `O`=100.
- N=5: 3 yes ballots, then `close` in the same cycle as a 4th (no) ballot → 4th ballot counted, `voted`=5'b01111, `O`=001.
- Ballots outside OPEN, plus `start` while OPEN → ignored; `yes_count` and timer unaffected.
- `rst` asserted mid-session with 2 yes ballots → all outputs return to reset values next edge, and no `done` occurs.
